// File: rtl/gbfact_rd_streamer.sv
// gbfact_rd_streamer: read-side initiator for the global-buffer factor RAM.
// Walks a wrapping address range, absorbs the one-cycle SRAM latency and
// streams words out through a 3-entry FIFO on a valid/ready interface.
// Optional feature macro: GBFACT_RD_STALL_CNT_EN (backpressure stall counter).
module gbfact_rd_streamer #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                      clk,
    input  logic                      RESET_N,
    input  logic                      cfg_start,
    input  logic [SRAM_DEPTH_BIT-1:0] cfg_base,
    input  logic [SRAM_DEPTH_BIT:0]   cfg_len,
    output logic                      busy,
    output logic                      done,
    output logic                      ram_read_en,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    input  logic [SRAM_WIDTH-1:0]     ram_data_out,
    output logic                      out_valid,
    output logic [SRAM_WIDTH-1:0]     out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [15:0]               stall_cnt
);
    localparam logic [SRAM_DEPTH_BIT-1:0] LP_ADDR_MAX = SRAM_DEPTH_BIT'(SRAM_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    logic                      r_busy;
    logic                      r_done;
    logic [SRAM_DEPTH_BIT:0]   r_len;
    logic [SRAM_DEPTH_BIT:0]   r_issued;
    logic [SRAM_DEPTH_BIT-1:0] r_next_addr;
    logic [SRAM_DEPTH_BIT-1:0] r_addr_hold;
    logic                      r_inflight;
    logic                      r_inflight_last;
    logic [SRAM_WIDTH-1:0]     r_fifo_data [0:2];
    logic [2:0]                r_fifo_last;
    logic [1:0]                r_wr_ptr;
    logic [1:0]                r_rd_ptr;
    logic [1:0]                r_cnt;

    logic                      w_credit;
    logic                      w_last_issue;
    logic                      w_rd_en;
    logic                      w_pop;
    logic                      w_accept;
    logic [SRAM_DEPTH_BIT-1:0] w_addr_nxt;

    // Credit counts words held plus the read still in flight; a pop in the
    // same cycle is not credited so the return write always has space.
    assign w_credit     = ({1'b0, r_cnt} + {2'b0, r_inflight}) < 3'd3;
    assign w_last_issue = (r_issued == r_len - 1'b1);
    assign w_rd_en      = (r_state == S_RUN) && w_credit;
    assign w_pop        = out_valid && out_ready;
    assign w_accept     = (r_state == S_IDLE) && cfg_start;
    assign w_addr_nxt   = (r_next_addr == LP_ADDR_MAX) ? '0 : r_next_addr + 1'b1;

    assign busy        = r_busy;
    assign done        = r_done;
    assign ram_read_en = w_rd_en;
    assign ram_addr_r  = w_rd_en ? r_next_addr : r_addr_hold;
    assign out_valid   = (r_cnt != 2'd0);
    assign out_data    = r_fifo_data[r_rd_ptr];
    assign out_last    = r_fifo_last[r_rd_ptr];

    // Control FSM: start acceptance, read issue/address walk, completion.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= '0;
            r_issued    <= '0;
            r_next_addr <= '0;
            r_addr_hold <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len != '0) begin
                            r_state     <= S_RUN;
                            r_busy      <= 1'b1;
                            r_len       <= cfg_len;
                            r_issued    <= '0;
                            r_next_addr <= cfg_base;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd_en) begin
                        r_issued    <= r_issued + 1'b1;
                        r_addr_hold <= r_next_addr;
                        r_next_addr <= w_addr_nxt;
                        if (w_last_issue)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Track the read in flight so its data lands in the FIFO next cycle.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && w_last_issue;
        end
    end

    // 3-entry ring FIFO; push is the returning read, pop is the handshake.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 3; i++) r_fifo_data[i] <= '0;
            r_fifo_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= ram_data_out;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
            case ({r_inflight, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef GBFACT_RD_STALL_CNT_EN
    logic [15:0] r_stall;

    // Saturating count of valid-not-ready cycles, cleared by a new transfer.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)
            r_stall <= '0;
        else if (w_accept)
            r_stall <= '0;
        else if (out_valid && !out_ready && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cnt = r_stall;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_gbfact_rd_streamer.sv
// Scoreboard bench for gbfact_rd_streamer: stimulus pushes expected words,
// a negedge monitor pops and compares on every stream handshake.
module tb_gbfact_rd_streamer;
    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        cfg_start = 1'b0;
    logic [5:0]  cfg_base = '0;
    logic [6:0]  cfg_len = '0;
    logic        busy, done, ram_read_en, out_valid, out_last;
    logic [5:0]  ram_addr_r;
    logic [27:0] ram_data_out = '0;
    logic [27:0] out_data;
    logic        out_ready = 1'b1;
    logic [15:0] stall_cnt;

    gbfact_rd_streamer dut (
        .clk(clk), .RESET_N(RESET_N), .cfg_start(cfg_start), .cfg_base(cfg_base),
        .cfg_len(cfg_len), .busy(busy), .done(done), .ram_read_en(ram_read_en),
        .ram_addr_r(ram_addr_r), .ram_data_out(ram_data_out), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: data equals address, one cycle read latency
    always @(posedge clk) if (ram_read_en) ram_data_out <= 28'(ram_addr_r);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [27:0] d; logic l; } exp_t;
    exp_t sbq[$];

    int n_cmp = 0, n_bad = 0;
    int t_start = 0, first_rd = -1, first_hs = -1, last_hs = -1, done_cyc = -1;
    int reads = 0, hs_total = 0, done_cnt = 0, stall_m = 0, credit_viol = 0;
    int tb_cnt = 0, tb_infl = 0;
    bit busy_seen = 0, hold_pend = 0, tog_mode = 0;
    logic [27:0] held_d;
    logic        held_l;
    logic [5:0]  exp_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: timing capture, address check, credit check, scoreboard pop
    always @(negedge clk) begin
        if (!RESET_N) begin
            tb_cnt = 0; tb_infl = 0; hold_pend = 0;
        end else begin
            if (cfg_start && !busy) begin
                t_start = cyc; first_rd = -1; first_hs = -1; last_hs = -1;
                done_cyc = -1; reads = 0; busy_seen = 0; stall_m = 0;
                exp_addr = cfg_base;
            end
            if (busy) busy_seen = 1;
            if (ram_read_en) begin
                if (tb_cnt + tb_infl >= 3) credit_viol++;
                chk("rd_addr", 32'(ram_addr_r), 32'(exp_addr));
                exp_addr = exp_addr + 6'd1;
                reads++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (done) begin done_cyc = cyc; done_cnt++; end
            if (hold_pend && out_valid) begin
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_last", 32'(out_last), 32'(held_l));
            end
            hold_pend = out_valid && !out_ready;
            held_d = out_data; held_l = out_last;
            if (out_valid && !out_ready) stall_m++;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_word actual=%0h required=none", out_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_last", 32'(out_last), 32'(e.l));
                end
                hs_total++;
                if (first_hs < 0) first_hs = cyc;
                if (out_last) last_hs = cyc;
            end
            tb_cnt = tb_cnt + tb_infl - ((out_valid && out_ready) ? 1 : 0);
            tb_infl = ram_read_en ? 1 : 0;
        end
    end

    // out_ready driver: steady high or toggling each cycle
    initial forever begin
        @(posedge clk); #1;
        out_ready = tog_mode ? ~out_ready : 1'b1;
    end

    task automatic start(input int base, input int len, input bit expect_accept);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_base = 6'(base); cfg_len = 7'(len);
        if (expect_accept)
            for (int i = 0; i < len; i++) begin
                exp_t e;
                e.d = 28'((base + i) % 64);
                e.l = (i == len - 1);
                sbq.push_back(e);
            end
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        bit got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk); #1;
            if (done_cnt > d0) got = 1;
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_rden"},  32'(ram_read_en), 32'd0);
        chk({tag, "_addr"},  32'(ram_addr_r), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data), 32'd0);
        chk({tag, "_last"},  32'(out_last), 32'd0);
        chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        int d0, h0;
        bit got;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("rst");
        RESET_N = 1'b1;
        repeat (2) @(posedge clk);

        // base 5, len 4, ready high: latency and throughput
        d0 = done_cnt;
        start(5, 4, 1);
        wait_done(d0, 40, "t1_done_seen");
        chk("t1_first_rd", 32'(first_rd - t_start), 32'd1);
        chk("t1_first_out", 32'(first_hs - t_start), 32'd3);
        chk("t1_last_out", 32'(last_hs - t_start), 32'd6);
        chk("t1_done_at", 32'(done_cyc - t_start), 32'd7);
        chk("t1_reads", 32'(reads), 32'd4);
        chk("t1_sb_empty", 32'(sbq.size()), 32'd0);

        // address wrap 62,63,0,1
        d0 = done_cnt;
        start(62, 4, 1);
        wait_done(d0, 40, "t2_done_seen");
        chk("t2_reads", 32'(reads), 32'd4);
        chk("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // zero length: immediate done, no reads, never busy
        d0 = done_cnt;
        start(9, 0, 1);
        wait_done(d0, 10, "t3_done_seen");
        chk("t3_done_at", 32'(done_cyc - t_start), 32'd1);
        chk("t3_reads", 32'(reads), 32'd0);
        chk("t3_busy_seen", 32'(busy_seen), 32'd0);

        // full depth with toggling backpressure
        tog_mode = 1;
        d0 = done_cnt;
        start(17, 64, 1);
        wait_done(d0, 400, "t4_done_seen");
        chk("t4_reads", 32'(reads), 32'd64);
        chk("t4_sb_empty", 32'(sbq.size()), 32'd0);
        chk("t4_credit_viol", 32'(credit_viol), 32'd0);
`ifdef GBFACT_RD_STALL_CNT_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 32'(stall_m));
`else
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        tog_mode = 0;
        repeat (2) @(posedge clk);

        // start while busy is ignored
        d0 = done_cnt;
        start(10, 6, 1);
        repeat (2) @(posedge clk);
        start(40, 2, 0);
        wait_done(d0, 60, "t5_done_seen");
        chk("t5_reads", 32'(reads), 32'd6);
        chk("t5_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
        repeat (4) @(posedge clk);
        chk("t5_no_late_done", 32'(done_cnt - d0), 32'd1);

        // reset after three words, then fresh transfer
        h0 = hs_total;
        start(30, 10, 1);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk); #1;
            if (hs_total >= h0 + 3) got = 1;
        end
        chk("t6_three_words", 32'(got), 32'd1);
        RESET_N = 1'b0;
        #1 chk_reset_outs("t6_midrst");
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 RESET_N = 1'b1;
        d0 = done_cnt;
        start(50, 5, 1);
        wait_done(d0, 40, "t6_done_seen");
        chk("t6_reads", 32'(reads), 32'd5);
        chk("t6_first_out", 32'(first_hs - t_start), 32'd3);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);
        chk("credit_viol_total", 32'(credit_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gbfact_rd_streamer.md
# gbfact_rd_streamer

Read-side initiator for the global-buffer factor RAM wrapper. On a start command it walks a contiguous (wrapping) address range, drives the wrapper's `read_en`/`addr_r`, absorbs the one-cycle SRAM read latency, and presents words on a valid/ready stream toward the PE array. A 3-entry output FIFO gives full throughput under backpressure without re-reading the SRAM.

## Interface
- `SRAM_DEPTH_BIT`, 6, address width of the factor RAM
- `SRAM_DEPTH`, 2**SRAM_DEPTH_BIT, number of words
- `SRAM_WIDTH`, 28, word width

- `clk`  in  1  single clock; all logic on posedge
- `RESET_N`  in  1  reset, asynchronous, active-low
- `cfg_start`  in  1  start pulse; sampled only in IDLE
- `cfg_base`  in  SRAM_DEPTH_BIT  first address
- `cfg_len`  in  SRAM_DEPTH_BIT+1  word count, 0..SRAM_DEPTH
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at end of transfer
- `ram_read_en`  out  1  to wrapper `read_en`
- `ram_addr_r`  out  SRAM_DEPTH_BIT  to wrapper `addr_r`
- `ram_data_out`  in  SRAM_WIDTH  from wrapper `data_out`, valid the cycle after `ram_read_en`
- `out_valid`  out  1  stream word valid
- `out_data`  out  SRAM_WIDTH  stream word
- `out_last`  out  1  qualifies final word of transfer
- `out_ready`  in  1  downstream accept
- `stall_cnt`  out  16  backpressure stall counter (see Configuration)

## Operation
- FSM: IDLE → RUN on `cfg_start` with `cfg_len`≠0; IDLE → IDLE with one-cycle `done` on `cfg_start` with `cfg_len`=0 (no reads). RUN → DRAIN when final read issued. DRAIN → IDLE on handshake of the `out_last` word; `done` pulses the following cycle.
- `cfg_start` while busy is ignored; `cfg_base`/`cfg_len` latched only on accepted start.
- Issue rule (RUN): `ram_read_en`=1 iff `fifo_cnt + inflight < 3`; `inflight` is 1 if a read was issued last cycle. Pop in same cycle is not credited.
- Address: starts at `cfg_base`, +1 per issued read, wraps modulo SRAM_DEPTH (63 → 0 at default). `ram_addr_r` holds last value when `ram_read_en`=0.
- Return path: `ram_data_out` written into FIFO exactly one cycle after each issued read, unconditionally (credit rule guarantees space).
- FIFO: 3 entries, simultaneous push and pop allowed at any count including full-with-pop and empty-with-push (pushed word not visible until next cycle).
- `out_last` travels with the word whose issue index equals `cfg_len`-1.
- Handshake: word transfers when `out_valid && out_ready`; `out_data`/`out_last` stable while `out_valid && !out_ready`.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_read_en`=0, `ram_addr_r`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `stall_cnt`=0; FSM IDLE, FIFO empty. Reset mid-transfer discards FIFO and in-flight read.
- Start sampled at cycle T: `busy`=1 and first `ram_read_en` at T+1; data into FIFO end of T+2; first `out_valid` at T+3.
- `out_ready` held high: one word per cycle; last word at T+2+`cfg_len`; `done` at T+3+`cfg_len`.
- `done` and next accepted `cfg_start` may occur in the same cycle (FSM is IDLE during `done`).

## Configuration
- `GBFACT_RD_STALL_CNT_EN` defined: `stall_cnt` counts cycles with `out_valid && !out_ready`, cleared on accepted `cfg_start`, saturates at 16'hFFFF, held after `done`.
- Undefined: counter logic absent, `stall_cnt` tied to 0.

## Test plan
- Base 5, len 4, `out_ready`=1, RAM holds addr-as-data → reads 5,6,7,8 at T+1..T+4; stream 5,6,7,8 at T+3..T+6, `out_last` on 8, `done` at T+7.
- Base 62, len 4 → addresses 62,63,0,1; stream data matches; exactly 4 reads issued.
- Len 0 start → `done` at T+1, `ram_read_en` never asserted, `busy` stays 0.
- Len 64, `out_ready` toggling 1-0 each cycle → all 64 words in order, no loss/duplication, `ram_read_en` never issued with fifo_cnt+inflight=3; with macro, `stall_cnt`=number of valid-not-ready cycles.
- `cfg_start` with new base while busy → ignored, original transfer completes unchanged.
- `RESET_N` low mid-transfer (after 3 words) → all outputs to reset values immediately; fresh start afterward streams correctly from new base.
